// File: rtl/rv_rr_arbiter.sv
// Round-robin N:1 ready/valid arbiter with burst locking.
// Ports: clk, rst (sync, active-high), i_valid/i_ready/i_data per requester,
//   e_valid/e_ready/e_data registered egress, grant_idx current/last owner.
module rv_rr_arbiter #(
  parameter int N         = 4,
  parameter int DW        = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         i_valid,
  output logic [N-1:0]         i_ready,
  input  logic [N*DW-1:0]      i_data,
  output logic                 e_valid,
  input  logic                 e_ready,
  output logic [DW-1:0]        e_data,
  output logic [$clog2(N)-1:0] grant_idx
);

  localparam int GW = $clog2(N);
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] CMAX = CW'(MAX_BURST);
  localparam logic [CW-1:0] CONE = CW'(1);

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] burst_cnt;
  logic [CW-1:0] cnt_nx;
  logic [GW-1:0] sel;
  logic          has_sel;
  logic          keep;
  logic          ld;
  logic          xfer;

  assign ld   = !e_valid || e_ready;
  assign xfer = ld && has_sel && !rst;

  // Owner keeps the lock while valid and under its beat budget;
  // otherwise scan from the slot after the owner, the owner last.
  // Descending offsets so the nearest valid slot is written last.
  always_comb begin
    keep    = (state == BURST)
              && i_valid[grant_idx]
              && (burst_cnt < CMAX);
    has_sel = 1'b0;
    sel     = grant_idx;
    if (keep) begin
      has_sel = 1'b1;
    end else begin
      for (int off = N; off >= 1; off--) begin
        if (i_valid[(int'(grant_idx) + off) % N]) begin
          has_sel = 1'b1;
          sel     = GW'((int'(grant_idx) + off) % N);
        end
      end
    end
  end

  always_comb begin
    i_ready = '0;
    if (xfer) begin
      i_ready[sel] = 1'b1;
    end
  end

  // A transfer that hits the beat budget drops to IDLE so the
  // next arbitration rotates away from the owner.
  always_comb begin
    state_nx = state;
    cnt_nx   = burst_cnt;
    if (ld) begin
      if (has_sel) begin
        if (state == BURST && sel == grant_idx) begin
          cnt_nx = burst_cnt + CONE;
        end else begin
          cnt_nx = CONE;
        end
        state_nx = (cnt_nx < CMAX) ? BURST : IDLE;
      end else begin
        state_nx = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      burst_cnt <= '0;
    end else begin
      state     <= state_nx;
      burst_cnt <= cnt_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      e_valid   <= 1'b0;
      e_data    <= '0;
      grant_idx <= GW'(N - 1);
    end else if (ld) begin
      if (has_sel) begin
        e_valid   <= 1'b1;
        e_data    <= i_data[int'(sel)*DW +: DW];
        grant_idx <= sel;
      end else begin
        e_valid <= 1'b0;
      end
    end
  end

endmodule
